ltl_report_collector: RTL and testbench

LTL_REPORT_COLLECTOR -- requirements
Module: ltl_report_collector

---
 rtl/ltl_monitor_pkg.sv | 20 ++
 rtl/ltl_report_fifo.sv | 54 +++++
 rtl/ltl_report_collector.sv | 104 ++++++++++
 tb/tb_ltl_report_collector.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ltl_monitor_pkg.sv
// Shared types and default constants for the LTL monitor report path.
// Defines the report entry layout, the collector FSM states and the default parameter values.
package ltl_monitor_pkg;

   localparam int DEF_NUM_REPORTS = 4;
   localparam int DEF_DEPTH       = 8;
   localparam int DEF_OFFSET_W    = 16;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // Entry layout at the default widths; the datapath packs {offset, vec} in this order.
   typedef struct packed {
      logic [DEF_OFFSET_W-1:0]    offset;
      logic [DEF_NUM_REPORTS-1:0] vec;
   } report_entry_t;

endpackage

// File: rtl/ltl_report_fifo.sv
// First-word-fall-through report queue with full/empty flags and synchronous flush.
// The pointers carry one extra wrap bit so that full and empty can be told apart.
module ltl_report_fifo
   import ltl_monitor_pkg::*;
#(
   parameter int WIDTH = DEF_OFFSET_W + DEF_NUM_REPORTS,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_ok;
   logic             rd_ok;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_ok = rd_en && !empty && !clear;
   // A push into a full queue is accepted only when the head leaves in the same cycle.
   assign wr_ok = wr_en && (!full || rd_ok) && !clear;

   // Head is forced to zero while empty so the unreset storage never leaks out.
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/ltl_report_collector.sv
// Collects automaton report vectors tagged with their symbol offset into a FWFT queue,
// tracking run activity, overflow and a saturating count of dropped reports.
module ltl_report_collector
   import ltl_monitor_pkg::*;
#(
   parameter int NUM_REPORTS = DEF_NUM_REPORTS,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int OFFSET_W    = DEF_OFFSET_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   clear,
   input  logic [NUM_REPORTS-1:0] report,
   output logic                   rpt_valid,
   input  logic                   rpt_ready,
   output logic [OFFSET_W-1:0]    rpt_offset,
   output logic [NUM_REPORTS-1:0] rpt_vec,
   output logic                   overflow,
   output logic [7:0]             drop_cnt,
   output logic                   active
);

   localparam int ENTRY_W = OFFSET_W + NUM_REPORTS;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t              state;
   logic [OFFSET_W-1:0] offset;
   logic                push_req;
   logic                pop;
   logic                drop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [ENTRY_W-1:0]  head;

   assign push_req = run && (report != '0) && !clear;
   assign pop      = !fifo_empty && rpt_ready && !clear;
   assign drop     = push_req && fifo_full && !pop;

   ltl_report_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .wr_en   (push_req),
      .wr_data ({offset, report}),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign rpt_valid  = !fifo_empty;
   assign rpt_offset = head[ENTRY_W-1:NUM_REPORTS];
   assign rpt_vec    = head[NUM_REPORTS-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         active   <= 1'b0;
         offset   <= '0;
         overflow <= 1'b0;
         drop_cnt <= 8'd0;
      end else if (clear) begin
         state    <= ST_IDLE;
         active   <= 1'b0;
         offset   <= '0;
         overflow <= 1'b0;
         drop_cnt <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (run) begin
                  state  <= ST_ACTIVE;
                  active <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (!run) begin
                  state  <= ST_IDLE;
                  active <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               active <= 1'b0;
            end
         endcase
         // The offset tags the current symbol, so it advances after being captured and
         // restarts from zero whenever the symbol stream pauses.
         offset <= run ? offset + OFFSET_W'(1) : '0;
         if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc8(drop_cnt);
         end
      end
   end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Bench for ltl_report_collector: a default instance and a 4-bit-offset instance share stimulus
// and are compared every cycle against a queue-based reference of the report collector.
module tb_ltl_report_collector;
   import ltl_monitor_pkg::*;

   logic        clk;
   logic        reset;
   logic        run;
   logic        clear;
   logic [3:0]  report;
   logic        rpt_ready;

   logic        rpt_valid;
   logic [15:0] rpt_offset;
   logic [3:0]  rpt_vec;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic        active;

   logic        w_rpt_valid;
   logic [3:0]  w_rpt_offset;
   logic [3:0]  w_rpt_vec;
   logic        w_overflow;
   logic [7:0]  w_drop_cnt;
   logic        w_active;

   int checks = 0;
   int errors = 0;

   report_entry_t mq[$];
   int unsigned   m_cnt;
   bit            m_ovf;
   int            m_drop;
   bit            m_act;

   ltl_report_collector dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .clear      (clear),
      .report     (report),
      .rpt_valid  (rpt_valid),
      .rpt_ready  (rpt_ready),
      .rpt_offset (rpt_offset),
      .rpt_vec    (rpt_vec),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt),
      .active     (active)
   );

   ltl_report_collector #(.NUM_REPORTS(4), .DEPTH(8), .OFFSET_W(4)) dut_w4 (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .clear      (clear),
      .report     (report),
      .rpt_valid  (w_rpt_valid),
      .rpt_ready  (rpt_ready),
      .rpt_offset (w_rpt_offset),
      .rpt_vec    (w_rpt_vec),
      .overflow   (w_overflow),
      .drop_cnt   (w_drop_cnt),
      .active     (w_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
      m_act  = 1'b0;
   endtask

   // Advances the reference by one clock edge using the inputs currently applied.
   task automatic model_update();
      report_entry_t e;
      bit do_pop;
      if (clear) begin
         model_reset();
      end else begin
         do_pop = (mq.size() != 0) && rpt_ready;
         if (do_pop) void'(mq.pop_front());
         if (run && report != 4'd0) begin
            if (mq.size() < 8) begin
               e.offset = m_cnt[15:0];
               e.vec    = report;
               mq.push_back(e);
            end else begin
               m_ovf = 1'b1;
               if (m_drop < 255) m_drop++;
            end
         end
         m_cnt = run ? m_cnt + 1 : 0;
         m_act = run;
      end
   endtask

   task automatic chk_outputs();
      logic        ev;
      logic [15:0] eo;
      logic [3:0]  evec;
      ev   = (mq.size() != 0);
      eo   = ev ? mq[0].offset : 16'd0;
      evec = ev ? mq[0].vec : 4'd0;
      chk("valid",       32'(rpt_valid),    32'(ev));
      chk("offset",      32'(rpt_offset),   32'(eo));
      chk("vec",         32'(rpt_vec),      32'(evec));
      chk("overflow",    32'(overflow),     32'(m_ovf));
      chk("drop_cnt",    32'(drop_cnt),     32'(m_drop));
      chk("active",      32'(active),       32'(m_act));
      chk("w4_valid",    32'(w_rpt_valid),  32'(ev));
      chk("w4_offset",   32'(w_rpt_offset), 32'(eo[3:0]));
      chk("w4_vec",      32'(w_rpt_vec),    32'(evec));
      chk("w4_overflow", 32'(w_overflow),   32'(m_ovf));
      chk("w4_drop_cnt", 32'(w_drop_cnt),   32'(m_drop));
      chk("w4_active",   32'(w_active),     32'(m_act));
   endtask

   // Called at a falling edge: applies inputs, confirms no same-cycle bypass, clocks, checks.
   task automatic step(input logic r, input logic c, input logic [3:0] rep, input logic rdy);
      run       = r;
      clear     = c;
      report    = rep;
      rpt_ready = rdy;
      #1;
      chk("pre_edge_valid", 32'(rpt_valid), 32'(mq.size() != 0));
      @(posedge clk);
      model_update();
      @(negedge clk);
      chk_outputs();
   endtask

   initial begin
      reset     = 1'b1;
      run       = 1'b0;
      clear     = 1'b0;
      report    = 4'd0;
      rpt_ready = 1'b0;
      model_reset();
      #1;
      chk_outputs();
      @(negedge clk);
      reset = 1'b0;
      chk_outputs();

      // Single report on the third of five symbols.
      step(1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b1, 1'b0, 4'b0000, 1'b0);
      chk("r33_not_yet", 32'(rpt_valid), 32'd0);
      step(1'b1, 1'b0, 4'b0100, 1'b0);
      chk("r33_valid",  32'(rpt_valid),  32'd1);
      chk("r33_offset", 32'(rpt_offset), 32'd2);
      chk("r33_vec",    32'(rpt_vec),    32'h4);
      step(1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b1, 1'b0, 4'b0000, 1'b0);
      chk("r33_hold_offset", 32'(rpt_offset), 32'd2);
      step(1'b0, 1'b0, 4'b0000, 1'b1);
      chk("r33_single", 32'(rpt_valid), 32'd0);

      // Nine reports into an eight-deep queue with no consumer.
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 4'b0001, 1'b0);
      chk("r34_overflow", 32'(overflow),   32'd1);
      chk("r34_drop",     32'(drop_cnt),   32'd1);
      chk("r34_head",     32'(rpt_offset), 32'd0);

      // Full queue with a pop and a push together.
      step(1'b1, 1'b0, 4'b0001, 1'b1);
      chk("r35_drop", 32'(drop_cnt),   32'd1);
      chk("r35_head", 32'(rpt_offset), 32'd1);

      // Clear against a simultaneous push and pop.
      step(1'b1, 1'b1, 4'b0001, 1'b1);
      chk("r38_valid",    32'(rpt_valid), 32'd0);
      chk("r38_overflow", 32'(overflow),  32'd0);
      chk("r38_drop",     32'(drop_cnt),  32'd0);
      chk("r38_active",   32'(active),    32'd0);

      // Drop counter saturation.
      step(1'b0, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 270; i++) step(1'b1, 1'b0, 4'b0010, 1'b0);
      chk("sat_drop", 32'(drop_cnt), 32'd255);
      step(1'b0, 1'b1, 4'd0, 1'b0);

      // Offset wrap on the 4-bit instance.
      for (int i = 0; i < 17; i++)
         step(1'b1, 1'b0, (i == 0 || i == 16) ? 4'b1000 : 4'b0000, 1'b0);
      step(1'b0, 1'b0, 4'd0, 1'b0);
      chk("wrap_first_w4", 32'(w_rpt_offset), 32'd0);
      step(1'b0, 1'b0, 4'd0, 1'b1);
      chk("wrap_second_w4",  32'(w_rpt_offset), 32'd0);
      chk("wrap_second_def", 32'(rpt_offset),   32'd16);
      step(1'b0, 1'b1, 4'd0, 1'b0);

      // Asynchronous reset with three entries queued.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'(i + 1), 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid",    32'(rpt_valid),   32'd0);
      chk("arst_offset",   32'(rpt_offset),  32'd0);
      chk("arst_vec",      32'(rpt_vec),     32'd0);
      chk("arst_active",   32'(active),      32'd0);
      chk("arst_w4_valid", 32'(w_rpt_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      chk_outputs();
      step(1'b0, 1'b0, 4'd0, 1'b1);
      chk("arst_empty_after", 32'(rpt_valid), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         logic       r;
         logic       c;
         logic [3:0] rep;
         logic       rdy;
         r   = ($urandom_range(0, 3) != 0);
         c   = ($urandom_range(0, 99) == 0);
         rep = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
         rdy = ($urandom_range(0, 2) == 0);
         step(r, c, rep, rdy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
